// File: rtl/mem_arb3_pkg.sv
// Shared definitions for the three-way memory arbiter: state encoding,
// requester indices, bus widths and the abort pattern.
package mem_arb_pkg;
    localparam int AW = 18;
    localparam int DW = 36;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] REQ_APR  = 2'd0;
    localparam logic [1:0] REQ_HOST = 2'd1;
    localparam logic [1:0] REQ_CONS = 2'd2;

    localparam logic [DW-1:0] TMO_PATTERN = 36'o777777777777;

    // Requester index 'step' positions after 'base' in circular order 0,1,2.
    function automatic logic [1:0] rr_next(input logic [1:0] base, input int step);
        int s;
        s = (int'(base) + step) % 3;
        return 2'(s);
    endfunction
endpackage

// File: rtl/mem_arb3_if.sv
// Requester and memory-master signal bundle; master is the arbiter's view,
// slave is the requesters-plus-memory environment.
interface mem_arb3_if;
    import mem_arb_pkg::*;

    logic [AW-1:0] s0_address, s1_address, s2_address;
    logic          s0_write, s1_write, s2_write;
    logic          s0_read, s1_read, s2_read;
    logic [DW-1:0] s0_writedata, s1_writedata, s2_writedata;
    logic [DW-1:0] s0_readdata, s1_readdata, s2_readdata;
    logic          s0_waitrequest, s1_waitrequest, s2_waitrequest;

    logic [AW-1:0] m_address;
    logic          m_write, m_read;
    logic [DW-1:0] m_writedata, m_readdata;
    logic          m_waitrequest;
    logic          timeout_err;

    modport master (
        input  s0_address, s1_address, s2_address,
        input  s0_write, s1_write, s2_write,
        input  s0_read, s1_read, s2_read,
        input  s0_writedata, s1_writedata, s2_writedata,
        output s0_readdata, s1_readdata, s2_readdata,
        output s0_waitrequest, s1_waitrequest, s2_waitrequest,
        output m_address, m_write, m_read, m_writedata,
        input  m_readdata, m_waitrequest,
        output timeout_err
    );

    modport slave (
        output s0_address, s1_address, s2_address,
        output s0_write, s1_write, s2_write,
        output s0_read, s1_read, s2_read,
        output s0_writedata, s1_writedata, s2_writedata,
        input  s0_readdata, s1_readdata, s2_readdata,
        input  s0_waitrequest, s1_waitrequest, s2_waitrequest,
        input  m_address, m_write, m_read, m_writedata,
        output m_readdata, m_waitrequest,
        input  timeout_err
    );
endinterface

// File: rtl/mem_arb3_rr_pick3.sv
// Combinational winner select: optional strict priority for requester 0,
// otherwise first requester after 'last' in circular order.
module rr_pick3
    import mem_arb_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    input  logic       prio0,
    output logic [1:0] win,
    output logic       any
);
    always_comb begin
        win = last;
        any = |req;
        if (prio0 && req[REQ_APR]) begin
            win = REQ_APR;
        end else begin
            // Walk farthest-first so the nearest requester after 'last' wins.
            for (int k = 3; k >= 1; k--) begin
                if (req[rr_next(last, k)]) win = rr_next(last, k);
            end
        end
    end
endmodule

// File: rtl/mem_arb3.sv
// Three-way arbiter for a single Avalon memory master with registered
// command outputs, per-requester read data and a stall watchdog.
module mem_arb3
    import mem_arb_pkg::*;
#(
    parameter bit PRIO0   = 1'b0,
    parameter int TIMEOUT = 1023
) (
    input logic       clk,
    input logic       reset,
    mem_arb3_if.master bus
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [2:0]         rd, wr, req, wait_q;
    logic [2:0][AW-1:0] addr;
    logic [2:0][DW-1:0] wdata, rdata;
    logic [1:0]         grant, last, win;
    logic               any;
    logic [CW-1:0]      cnt;
    state_t             state;

    assign rd    = {bus.s2_read, bus.s1_read, bus.s0_read};
    assign wr    = {bus.s2_write, bus.s1_write, bus.s0_write};
    assign addr  = {bus.s2_address, bus.s1_address, bus.s0_address};
    assign wdata = {bus.s2_writedata, bus.s1_writedata, bus.s0_writedata};
    assign req   = rd | wr;

    rr_pick3 u_pick (
        .req   (req),
        .last  (last),
        .prio0 (PRIO0),
        .win   (win),
        .any   (any)
    );

    for (genvar n = 0; n < 3; n++) begin : g_wait
        assign wait_q[n] = req[n] & ~(state == DONE && grant == 2'(n));
    end

    assign {bus.s2_waitrequest, bus.s1_waitrequest, bus.s0_waitrequest} = wait_q;
    assign bus.s0_readdata = rdata[0];
    assign bus.s1_readdata = rdata[1];
    assign bus.s2_readdata = rdata[2];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= IDLE;
            grant           <= REQ_APR;
            last            <= REQ_CONS;
            cnt             <= '0;
            rdata           <= '0;
            bus.m_address   <= '0;
            bus.m_writedata <= '0;
            bus.m_write     <= 1'b0;
            bus.m_read      <= 1'b0;
            bus.timeout_err <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any) begin
                        grant           <= win;
                        last            <= win;
                        bus.m_address   <= addr[win];
                        bus.m_writedata <= wdata[win];
                        bus.m_write     <= wr[win];
                        bus.m_read      <= ~wr[win] & rd[win];
                        cnt             <= '0;
                        state           <= BUSY;
                    end
                end
                BUSY: begin
                    if (!bus.m_waitrequest) begin
                        bus.m_write <= 1'b0;
                        bus.m_read  <= 1'b0;
                        if (bus.m_read) rdata[grant] <= bus.m_readdata;
                        state <= DONE;
                    end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
                        // Abort: hand the requester an all-ones word so it can't hang.
                        bus.m_write     <= 1'b0;
                        bus.m_read      <= 1'b0;
                        rdata[grant]    <= TMO_PATTERN;
                        bus.timeout_err <= 1'b1;
                        state           <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arb3.sv
// Drives a round-robin and a strict-priority arbiter with shared stimulus and
// checks both against a transaction-level model every cycle.
module tb_mem_arb3;
    import mem_arb_pkg::*;

    localparam int TMO = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]    s_rd = '0, s_wr = '0;
    logic [AW-1:0] s_addr [3];
    logic [DW-1:0] s_wd [3];
    logic          m_wait = 1'b0;
    logic [DW-1:0] m_rdata = '0;

    mem_arb3_if ifr();
    mem_arb3_if ifp();

    mem_arb3 #(.PRIO0(1'b0), .TIMEOUT(TMO)) dut_rr (.clk(clk), .reset(reset), .bus(ifr.master));
    mem_arb3 #(.PRIO0(1'b1), .TIMEOUT(TMO)) dut_pr (.clk(clk), .reset(reset), .bus(ifp.master));

    assign ifr.s0_address = s_addr[0];   assign ifp.s0_address = s_addr[0];
    assign ifr.s1_address = s_addr[1];   assign ifp.s1_address = s_addr[1];
    assign ifr.s2_address = s_addr[2];   assign ifp.s2_address = s_addr[2];
    assign ifr.s0_writedata = s_wd[0];   assign ifp.s0_writedata = s_wd[0];
    assign ifr.s1_writedata = s_wd[1];   assign ifp.s1_writedata = s_wd[1];
    assign ifr.s2_writedata = s_wd[2];   assign ifp.s2_writedata = s_wd[2];
    assign ifr.s0_read = s_rd[0];        assign ifp.s0_read = s_rd[0];
    assign ifr.s1_read = s_rd[1];        assign ifp.s1_read = s_rd[1];
    assign ifr.s2_read = s_rd[2];        assign ifp.s2_read = s_rd[2];
    assign ifr.s0_write = s_wr[0];       assign ifp.s0_write = s_wr[0];
    assign ifr.s1_write = s_wr[1];       assign ifp.s1_write = s_wr[1];
    assign ifr.s2_write = s_wr[2];       assign ifp.s2_write = s_wr[2];
    assign ifr.m_waitrequest = m_wait;   assign ifp.m_waitrequest = m_wait;
    assign ifr.m_readdata = m_rdata;     assign ifp.m_readdata = m_rdata;

    // Observed outputs, index 0 = round-robin DUT, 1 = priority DUT.
    logic [2:0]    wq [2];
    logic [DW-1:0] rq [2][3];
    logic [AW-1:0] o_addr [2];
    logic [DW-1:0] o_wd [2];
    logic          o_rd [2], o_wr [2], o_err [2];

    assign wq[0] = {ifr.s2_waitrequest, ifr.s1_waitrequest, ifr.s0_waitrequest};
    assign wq[1] = {ifp.s2_waitrequest, ifp.s1_waitrequest, ifp.s0_waitrequest};
    assign rq[0][0] = ifr.s0_readdata; assign rq[0][1] = ifr.s1_readdata; assign rq[0][2] = ifr.s2_readdata;
    assign rq[1][0] = ifp.s0_readdata; assign rq[1][1] = ifp.s1_readdata; assign rq[1][2] = ifp.s2_readdata;
    assign o_addr[0] = ifr.m_address;   assign o_addr[1] = ifp.m_address;
    assign o_wd[0]   = ifr.m_writedata; assign o_wd[1]   = ifp.m_writedata;
    assign o_rd[0]   = ifr.m_read;      assign o_rd[1]   = ifp.m_read;
    assign o_wr[0]   = ifr.m_write;     assign o_wr[1]   = ifp.m_write;
    assign o_err[0]  = ifr.timeout_err; assign o_err[1]  = ifp.timeout_err;

    int n_chk = 0;
    int n_err = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 20) $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Transaction-level model: who owns the memory, whether this is the
    // completion cycle, and how many stalled cycles the transfer has seen.
    int            own [2]    = '{-1, -1};
    bit            fin [2]    = '{0, 0};
    int            lastm [2]  = '{2, 2};
    int            stalls [2] = '{0, 0};
    logic [AW-1:0] e_addr [2] = '{0, 0};
    logic [DW-1:0] e_wd [2]   = '{0, 0};
    bit            e_rd [2]   = '{0, 0};
    bit            e_wr [2]   = '{0, 0};
    bit            e_err [2]  = '{0, 0};
    logic [DW-1:0] e_rdata [2][3];

    task automatic model_edge(input int k);
        int w;
        if (!reset) begin
            own[k] = -1; fin[k] = 0; lastm[k] = 2; stalls[k] = 0;
            e_addr[k] = '0; e_wd[k] = '0; e_rd[k] = 0; e_wr[k] = 0; e_err[k] = 0;
            for (int n = 0; n < 3; n++) e_rdata[k][n] = '0;
        end else if (fin[k]) begin
            fin[k] = 0;
            own[k] = -1;
        end else if (own[k] >= 0) begin
            if (!m_wait) begin
                if (e_rd[k]) e_rdata[k][own[k]] = m_rdata;
                e_rd[k] = 0; e_wr[k] = 0; fin[k] = 1;
            end else begin
                stalls[k]++;
                if (stalls[k] == TMO) begin
                    e_rdata[k][own[k]] = 36'o777777777777;
                    e_err[k] = 1; e_rd[k] = 0; e_wr[k] = 0; fin[k] = 1;
                end
            end
        end else begin
            w = -1;
            if (k == 1 && (s_rd[0] | s_wr[0])) w = 0;
            else for (int j = 1; j <= 3 && w < 0; j++) begin
                int c;
                c = (lastm[k] + j) % 3;
                if (s_rd[c] | s_wr[c]) w = c;
            end
            if (w >= 0) begin
                own[k] = w; lastm[k] = w; stalls[k] = 0;
                e_addr[k] = s_addr[w]; e_wd[k] = s_wd[w];
                e_wr[k] = s_wr[w]; e_rd[k] = !s_wr[w] && s_rd[w];
            end
        end
    endtask

    always @(posedge clk) begin
        model_edge(0);
        model_edge(1);
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            for (int k = 0; k < 2; k++) begin
                logic [2:0] ew;
                for (int n = 0; n < 3; n++)
                    ew[n] = (s_rd[n] | s_wr[n]) && !(fin[k] && own[k] == n);
                chk($sformatf("dut%0d m_read", k), o_rd[k], e_rd[k]);
                chk($sformatf("dut%0d m_write", k), o_wr[k], e_wr[k]);
                chk($sformatf("dut%0d m_address", k), o_addr[k], e_addr[k]);
                chk($sformatf("dut%0d m_writedata", k), o_wd[k], e_wd[k]);
                chk($sformatf("dut%0d timeout_err", k), o_err[k], e_err[k]);
                chk($sformatf("dut%0d waitrequest", k), wq[k], ew);
                for (int n = 0; n < 3; n++)
                    chk($sformatf("dut%0d s%0d_readdata", k, n), rq[k][n], e_rdata[k][n]);
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int stuck;
        stuck = 0;
        for (int n = 0; n < 3; n++) begin s_addr[n] = '0; s_wd[n] = '0; end
        nxt();
        cmp_on = 1'b1;
        nxt();
        chk("reset m_read", o_rd[0], 1'b0);
        chk("reset m_write", o_wr[0], 1'b0);
        chk("reset timeout_err", o_err[0], 1'b0);
        chk("reset s1_readdata", rq[0][1], '0);
        reset = 1'b1;

        // Single read with two stall cycles.
        s_rd[1] = 1'b1; s_addr[1] = 18'o001234; m_wait = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            nxt();
            chk("rd m_read", o_rd[0], 1'b1);
            chk("rd m_address", o_addr[0], 18'o001234);
            chk("rd s1_wait busy", wq[0][1], 1'b1);
            if (t == 3) begin m_wait = 1'b0; m_rdata = 36'o123456765432; end
        end
        nxt();
        chk("rd s1_readdata", rq[0][1], 36'o123456765432);
        chk("rd s1_wait done", wq[0][1], 1'b0);
        s_rd[1] = 1'b0; m_rdata = '0;
        nxt();
        chk("rd s1_wait idle", wq[0][1], 1'b0);

        // Read+write together: write wins, readdata untouched.
        s_rd[2] = 1'b1; s_wr[2] = 1'b1; s_wd[2] = 36'o707070707070; s_addr[2] = 18'o000777;
        nxt();
        chk("wp m_write", o_wr[0], 1'b1);
        chk("wp m_read", o_rd[0], 1'b0);
        chk("wp m_writedata", o_wd[0], 36'o707070707070);
        nxt();
        chk("wp s2_wait done", wq[0][2], 1'b0);
        chk("wp s2_readdata", rq[0][2], '0);
        s_rd[2] = 1'b0; s_wr[2] = 1'b0;
        nxt();

        // All three requesting from reset: rr serves 0,1,2,... while prio serves s0 only.
        reset = 1'b0; nxt(); reset = 1'b1;
        s_rd = 3'b111; s_addr[0] = 18'o000010; s_addr[1] = 18'o000020; s_addr[2] = 18'o000030;
        m_rdata = 36'd1000;
        for (int t = 1; t <= 20; t++) begin
            nxt();
            if (t <= 17) begin
                if (t >= 2 && (t - 2) % 3 == 0) begin
                    int o;
                    o = ((t - 2) / 3) % 3;
                    chk("rr wait done", wq[0], 3'b111 & ~(3'b001 << o));
                    chk("rr readdata", rq[0][o], 36'(1000 + t - 1));
                end else begin
                    chk("rr wait busy", wq[0], 3'b111);
                end
            end
            if (t == 18) chk("rr wait s1 only", wq[0], 3'b010);
            if (t <= 19) chk("prio s1 starved", wq[1][1], 1'b1);
            if (t == 20) begin
                chk("prio s1 granted", wq[1][1], 1'b0);
                chk("prio s1 readdata", rq[1][1], 36'd1019);
            end
            m_rdata = 36'(1000 + t);
            if (t == 17) begin s_rd[0] = 1'b0; s_rd[2] = 1'b0; end
        end
        s_rd = '0;
        nxt();

        // Watchdog: memory stuck on an s0 read.
        s_rd[0] = 1'b1; s_addr[0] = 18'o000100; m_wait = 1'b1;
        for (int t = 1; t <= 9; t++) begin
            nxt();
            if (t <= 8) begin
                chk("tmo m_read held", o_rd[0], 1'b1);
                chk("tmo err clear", o_err[0], 1'b0);
            end else begin
                chk("tmo m_read drop", o_rd[0], 1'b0);
                chk("tmo s0_readdata", rq[0][0], 36'o777777777777);
                chk("tmo err set", o_err[0], 1'b1);
                chk("tmo s0_wait", wq[0][0], 1'b0);
            end
        end
        s_rd[0] = 1'b0; m_wait = 1'b0;
        nxt();
        s_wr[1] = 1'b1;
        nxt(); nxt();
        s_wr[1] = 1'b0;
        nxt();
        chk("tmo err sticky", o_err[0], 1'b1);

        // Reset while BUSY.
        s_rd[0] = 1'b1; m_wait = 1'b1;
        nxt(); nxt();
        reset = 1'b0;
        nxt();
        chk("rst m_read", o_rd[0], 1'b0);
        chk("rst timeout_err", o_err[0], 1'b0);
        chk("rst wait", wq[0], 3'b001);
        reset = 1'b1;
        nxt();
        chk("rst regrant", o_rd[0], 1'b1);
        m_wait = 1'b0;
        nxt();
        s_rd[0] = 1'b0;
        nxt(); nxt();

        // Randomised traffic with stalls, stuck memory, withdrawals and resets.
        for (int t = 0; t < 4000; t++) begin
            for (int n = 0; n < 3; n++) begin
                if ($urandom_range(0, 3) == 0) begin
                    s_rd[n] = 1'($urandom_range(0, 1));
                    s_wr[n] = ($urandom_range(0, 2) == 0);
                end
                s_addr[n] = 18'($urandom);
                s_wd[n] = {4'($urandom), 32'($urandom)};
            end
            if (stuck > 0) begin
                m_wait = 1'b1;
                stuck--;
            end else begin
                m_wait = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 150) == 0) stuck = 12;
            end
            m_rdata = {4'($urandom), 32'($urandom)};
            reset = ($urandom_range(0, 400) != 0);
            nxt();
        end
        reset = 1'b1;
        nxt(); nxt();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
